// File: rtl/sram_resp_pkg.sv
//------------------------------------------------------------------------------
// sram_resp_pkg
// Shared types and constants for the SRAM-backed Avalon-MM responder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sram_resp_pkg;

  // Transaction sequencer states: request wait, low halfword, high halfword,
  // transfer acceptance.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Data returned for a read outside the populated SRAM window.
  localparam logic [31:0] c_OOR_RDATA = 32'h0;

  // Width of a counter that walks 0 .. cycles-1 (never narrower than 1 bit).
  function automatic int unsigned phase_cnt_w(input int unsigned cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_halfword_phase.sv
//------------------------------------------------------------------------------
// sram_halfword_phase
// Times one halfword access to the asynchronous SRAM: holds CE/OE/WE/byte
// lanes and the write data for ACCESS_CYCLES clocks, releases WE one clock
// before the end of a write, and captures read data at the end of a read.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sram_halfword_phase
  import sram_resp_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,      // first clock of a phase follows this edge
  input  logic        i_rw,         // 1 = write, 0 = read
  input  logic        i_hw,         // 0 = low halfword, 1 = high halfword
  input  logic [1:0]  i_be_n,       // active-low lanes for this halfword
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_dq_in,
  output logic        o_phase_done, // high during the last clock of a phase
  output logic [31:0] o_rdata,
  output logic        o_ce_n,
  output logic        o_oe_n,
  output logic        o_we_n,
  output logic        o_lb_n,
  output logic        o_ub_n,
  output logic        o_dq_oe,
  output logic [15:0] o_dq_out
);

  localparam int unsigned CW = phase_cnt_w(ACCESS_CYCLES);
  localparam logic [CW-1:0] c_LAST   = CW'(ACCESS_CYCLES - 1);
  localparam logic [CW-1:0] c_WE_END = CW'(ACCESS_CYCLES - 2);

  logic          r_active;
  logic [CW-1:0] r_cnt;
  logic          r_rw;
  logic          r_hw;
  logic          r_ce_n;
  logic          r_oe_n;
  logic          r_we_n;
  logic          r_lb_n;
  logic          r_ub_n;
  logic          r_dq_oe;
  logic [15:0]   r_dq_out;
  logic [31:0]   r_rdata;
  logic          w_last;

  assign w_last       = r_active && (r_cnt == c_LAST);
  assign o_phase_done = w_last;

  // Phase counter and SRAM strobes; a new start may coincide with the last
  // clock of the previous phase, so it takes priority over the teardown.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_rw     <= 1'b0;
      r_hw     <= 1'b0;
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_lb_n   <= 1'b1;
      r_ub_n   <= 1'b1;
      r_dq_oe  <= 1'b0;
      r_dq_out <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_rw     <= i_rw;
      r_hw     <= i_hw;
      r_ce_n   <= 1'b0;
      r_oe_n   <= i_rw;
      // Fully masked writes still run the full phase, just without a pulse.
      r_we_n   <= !(i_rw && (i_be_n != 2'b11));
      r_lb_n   <= i_rw ? i_be_n[0] : 1'b0;
      r_ub_n   <= i_rw ? i_be_n[1] : 1'b0;
      r_dq_oe  <= i_rw;
      r_dq_out <= i_rw ? i_wdata : 16'h0;
    end else if (r_active) begin
      if (w_last) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
        r_ce_n   <= 1'b1;
        r_oe_n   <= 1'b1;
        r_we_n   <= 1'b1;
        r_lb_n   <= 1'b1;
        r_ub_n   <= 1'b1;
        r_dq_oe  <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        // WE rises for the final clock so address/data outlive the pulse.
        if (r_cnt == c_WE_END) begin
          r_we_n <= 1'b1;
        end
      end
    end
  end

  // Capture the SRAM output at the end of the last clock of a read phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (w_last && !r_rw) begin
      if (r_hw) begin
        r_rdata[31:16] <= i_dq_in;
      end else begin
        r_rdata[15:0] <= i_dq_in;
      end
    end
  end

  assign o_rdata  = r_rdata;
  assign o_ce_n   = r_ce_n;
  assign o_oe_n   = r_oe_n;
  assign o_we_n   = r_we_n;
  assign o_lb_n   = r_lb_n;
  assign o_ub_n   = r_ub_n;
  assign o_dq_oe  = r_dq_oe;
  assign o_dq_out = r_dq_out;

endmodule

`default_nettype wire

// File: rtl/sram_avalon_responder.sv
//------------------------------------------------------------------------------
// sram_avalon_responder
// Avalon-MM responder with the SDRAM controller's s1 interface, storing each
// 32-bit word as two halfwords in a 16-bit asynchronous SRAM.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sram_avalon_responder
  import sram_resp_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int WORD_AW       = 19
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [22:0] s1_address,
  input  logic [3:0]  s1_byteenable_n,
  input  logic        s1_chipselect,
  input  logic [31:0] s1_writedata,
  input  logic        s1_read_n,
  input  logic        s1_write_n,
  output logic [31:0] s1_readdata,
  output logic        s1_readdatavalid,
  output logic        s1_waitrequest,
  inout  wire  [15:0] SRAM_DQ,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        o_busy,
  output logic        o_range_err,
  output logic        o_proto_err
);

  state_t        r_state;
  state_t        w_next;

  logic [WORD_AW-1:0] r_addr;
  logic [1:0]    r_be_hi;
  logic [15:0]   r_wdata_hi;
  logic          r_wr;
  logic          r_oor;
  logic [19:0]   r_sram_addr;
  logic [31:0]   r_readdata;
  logic          r_rdv;
  logic          r_wait;
  logic          r_busy;
  logic          r_range_err;
  logic          r_proto_err;

  logic          w_req;
  logic          w_req_wr;
  logic          w_req_oor;
  logic          w_start;
  logic          w_ph_rw;
  logic          w_ph_hw;
  logic [1:0]    w_ph_be;
  logic [15:0]   w_ph_wd;
  logic [19:0]   w_ph_addr;
  logic          w_phase_done;
  logic [31:0]   w_rdata;
  logic          w_dq_oe;
  logic          w_dq_drive;
  logic [15:0]   w_dq_out;

  // A simultaneous read+write is carried out as a write.
  assign w_req     = s1_chipselect && (!s1_read_n || !s1_write_n);
  assign w_req_wr  = !s1_write_n;
  assign w_req_oor = |(s1_address >> WORD_AW);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and the phase-engine request; in IDLE the phase takes the live
  // bus values because the latches only update on the same edge.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_ph_rw   = r_wr;
    w_ph_hw   = 1'b1;
    w_ph_be   = r_be_hi;
    w_ph_wd   = r_wdata_hi;
    w_ph_addr = 20'({r_addr, 1'b1});
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_req_oor) begin
            w_next = ST_DONE;
          end else begin
            w_next    = ST_LO;
            w_start   = 1'b1;
            w_ph_rw   = w_req_wr;
            w_ph_hw   = 1'b0;
            w_ph_be   = s1_byteenable_n[1:0];
            w_ph_wd   = s1_writedata[15:0];
            w_ph_addr = 20'({s1_address[WORD_AW-1:0], 1'b0});
          end
        end
      end
      ST_LO: begin
        if (w_phase_done) begin
          w_next  = ST_HI;
          w_start = 1'b1;
        end
      end
      ST_HI: begin
        if (w_phase_done) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Latch the request and raise sticky error flags when IDLE accepts it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr      <= '0;
      r_be_hi     <= 2'b11;
      r_wdata_hi  <= '0;
      r_wr        <= 1'b0;
      r_oor       <= 1'b0;
      r_range_err <= 1'b0;
      r_proto_err <= 1'b0;
    end else if (r_state == ST_IDLE && w_req) begin
      r_addr     <= s1_address[WORD_AW-1:0];
      r_be_hi    <= s1_byteenable_n[3:2];
      r_wdata_hi <= s1_writedata[31:16];
      r_wr       <= w_req_wr;
      r_oor      <= w_req_oor;
      if (w_req_oor) begin
        r_range_err <= 1'b1;
      end
      if (!s1_read_n && !s1_write_n) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // SRAM halfword address, loaded as each phase starts and held afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sram_addr <= '0;
    end else if (w_start) begin
      r_sram_addr <= w_ph_addr;
    end
  end

  // Bus handshake outputs, registered from the state being entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait     <= 1'b1;
      r_busy     <= 1'b0;
      r_rdv      <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_wait <= (w_next != ST_DONE);
      r_busy <= (w_next != ST_IDLE);
      if (r_state == ST_DONE && !r_wr) begin
        r_rdv      <= 1'b1;
        r_readdata <= r_oor ? c_OOR_RDATA : w_rdata;
      end else begin
        r_rdv <= 1'b0;
      end
    end
  end

  sram_halfword_phase #(
    .ACCESS_CYCLES (ACCESS_CYCLES)
  ) u_phase (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (w_start),
    .i_rw         (w_ph_rw),
    .i_hw         (w_ph_hw),
    .i_be_n       (w_ph_be),
    .i_wdata      (w_ph_wd),
    .i_dq_in      (SRAM_DQ),
    .o_phase_done (w_phase_done),
    .o_rdata      (w_rdata),
    .o_ce_n       (SRAM_CE_N),
    .o_oe_n       (SRAM_OE_N),
    .o_we_n       (SRAM_WE_N),
    .o_lb_n       (SRAM_LB_N),
    .o_ub_n       (SRAM_UB_N),
    .o_dq_oe      (w_dq_oe),
    .o_dq_out     (w_dq_out)
  );

  // The data bus is released the instant reset asserts, not at the next edge.
  assign w_dq_drive = w_dq_oe && i_rst_n;
  assign SRAM_DQ    = w_dq_drive ? w_dq_out : 16'hzzzz;

  assign SRAM_ADDR        = r_sram_addr;
  assign s1_readdata      = r_readdata;
  assign s1_readdatavalid = r_rdv;
  assign s1_waitrequest   = r_wait;
  assign o_busy           = r_busy;
  assign o_range_err      = r_range_err;
  assign o_proto_err      = r_proto_err;

endmodule

`default_nettype wire
